lfsr_rng: RTL and testbench

//  Parametrised Fibonacci-LFSR pseudo-random source for the Dino game logic (obstacle spacing, cloud/bird pick).

---
 rtl/lfsr_rng.sv | 141 ++++++++++++++
 tb/tb_lfsr_rng.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - Fibonacci LFSR random source with seeding and rejection-sampled draw port
module lfsr_rng #(
  parameter int               WIDTH   = 30,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(1),
  parameter int               OUT_W   = 8,
  parameter int               MAX_TRY = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             seed_we_i,
  input  logic [WIDTH-1:0] seed_in_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             req_i,
  input  logic [OUT_W-1:0] range_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [OUT_W-1:0] value_o
);

  localparam int TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  if (OUT_W > WIDTH) begin : g_bad_out_w
    $error("lfsr_rng: OUT_W must not exceed WIDTH");
  end
  if (MAX_TRY < 1) begin : g_bad_max_try
    $error("lfsr_rng: MAX_TRY must be at least 1");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_rng: SEED must be nonzero");
  end

  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] rng_q, rng_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [OUT_W-1:0] value_q, value_d;
  logic             fb;

  // Maximal-length tap sets, shift-left Fibonacci form
  if (WIDTH == 8) begin : g_t8
    assign fb = data_q[7] ^ data_q[5] ^ data_q[4] ^ data_q[3];
  end else if (WIDTH == 16) begin : g_t16
    assign fb = data_q[15] ^ data_q[14] ^ data_q[12] ^ data_q[3];
  end else if (WIDTH == 24) begin : g_t24
    assign fb = data_q[23] ^ data_q[22] ^ data_q[21] ^ data_q[16];
  end else if (WIDTH == 30) begin : g_t30
    assign fb = data_q[29] ^ data_q[5] ^ data_q[3] ^ data_q[0];
  end else if (WIDTH == 32) begin : g_t32
    assign fb = data_q[31] ^ data_q[21] ^ data_q[1] ^ data_q[0];
  end else begin : g_bad_width
    $error("lfsr_rng: WIDTH must be 8, 16, 24, 30 or 32");
    assign fb = 1'b0;
  end

  logic [OUT_W-1:0] rng_m1, mask, cand;
  logic             accept, last_try;

  assign rng_m1 = rng_q - OUT_W'(1);

  // Mask covers every bit at or below the top set bit of rng_q-1
  always_comb begin
    mask = '0;
    if (rng_q == '0) begin
      mask = '1;
    end else begin
      for (int i = 0; i < OUT_W; i++) begin
        mask[i] = |(rng_m1 >> i);
      end
    end
  end

  assign cand     = data_q[OUT_W-1:0] & mask;
  assign accept   = (rng_q == '0) || (cand < rng_q);
  assign last_try = (try_q == TRY_W'(MAX_TRY - 1));

  always_comb begin
    if (seed_we_i) begin
      data_d = (seed_in_i == '0) ? SEED : seed_in_i;
    end else if (en_i || (state_q == ST_SAMPLE)) begin
      data_d = {data_q[WIDTH-2:0], fb};
    end else begin
      data_d = data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    rng_d   = rng_q;
    try_d   = try_q;
    value_d = value_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          rng_d   = range_i;
          try_d   = '0;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (accept) begin
          value_d = cand;
          state_d = ST_DONE;
        end else if (last_try) begin
          value_d = cand - rng_q;
          state_d = ST_DONE;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= SEED;
      state_q <= ST_IDLE;
      rng_q   <= '0;
      try_q   <= '0;
      value_q <= '0;
    end else begin
      data_q  <= data_d;
      state_q <= state_d;
      rng_q   <= rng_d;
      try_q   <= try_d;
      value_q <= value_d;
    end
  end

  assign data_o  = data_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign value_o = value_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng
module tb_lfsr_rng;

  localparam int W  = 30;
  localparam int OW = 8;
  localparam int MT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, seed_we, req;
  logic [W-1:0]  seed_in, data;
  logic [OW-1:0] range_v, value;
  logic          busy, valid;

  logic          en8, seed_we8, req8;
  logic [7:0]    seed_in8, data8, range8, value8;
  logic          busy8, valid8;

  int total = 0;
  int bad   = 0;
  logic [63:0] mdl;

  lfsr_rng #(.WIDTH(30), .SEED(30'h1), .OUT_W(8), .MAX_TRY(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .seed_we_i(seed_we), .seed_in_i(seed_in),
    .data_o(data), .req_i(req), .range_i(range_v), .busy_o(busy), .valid_o(valid),
    .value_o(value)
  );

  lfsr_rng #(.WIDTH(8), .SEED(8'h1), .OUT_W(8), .MAX_TRY(16)) u_p8 (
    .clk_i(clk), .rst_i(rst), .en_i(en8), .seed_we_i(seed_we8), .seed_in_i(seed_in8),
    .data_o(data8), .req_i(req8), .range_i(range8), .busy_o(busy8), .valid_o(valid8),
    .value_o(value8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next LFSR state from the published tap list (1-based bit positions)
  function automatic logic [63:0] step_model(input logic [63:0] s, input int w);
    int taps[4];
    logic fb;
    case (w)
      8:       taps = '{8, 6, 5, 4};
      16:      taps = '{16, 15, 13, 4};
      24:      taps = '{24, 23, 22, 17};
      30:      taps = '{30, 6, 4, 1};
      default: taps = '{32, 22, 2, 1};
    endcase
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]-1];
    return ((s << 1) | 64'(fb)) & ((64'd1 << w) - 64'd1);
  endfunction

  function automatic void model_draw(input logic [63:0] s0, input int r, output int val,
                                     output int lat, output logic [63:0] s_end,
                                     output bit forced);
    int mask;
    int cand;
    logic [63:0] s;
    s = s0;
    mask = 0;
    forced = 1'b0;
    val = 0;
    lat = 0;
    if (r == 0) mask = (1 << OW) - 1;
    else while (mask < r - 1) mask = mask * 2 + 1;
    for (int t = 0; t < MT; t++) begin
      cand = int'(s[7:0]) & mask;
      s = step_model(s, W);
      if (r == 0 || cand < r) begin
        val = cand;
        lat = t + 2;
        break;
      end
      if (t == MT - 1) begin
        val = cand - r;
        lat = t + 2;
        forced = 1'b1;
      end
    end
    s_end = s;
  endfunction

  task automatic load_seed(input logic [W-1:0] s);
    seed_we = 1'b1;
    seed_in = s;
    tick();
    seed_we = 1'b0;
    mdl = (s == '0) ? 64'd1 : 64'(s);
    check("seed_load", data, mdl);
  endtask

  task automatic draw(input logic [OW-1:0] r, output int val_o, output int lat_o);
    int exp_val, exp_lat;
    logic [63:0] exp_end;
    bit forced;
    model_draw(mdl, int'(r), exp_val, exp_lat, exp_end, forced);
    req = 1'b1;
    range_v = r;
    tick();
    req = 1'b0;
    lat_o = 1;
    while (valid !== 1'b1 && lat_o < MT + 4) begin
      check("busy_in_draw", busy, 1);
      req = 1'($urandom_range(0, 1));
      range_v = OW'($urandom);
      tick();
      lat_o++;
    end
    req = 1'b0;
    val_o = int'(value);
    check("draw_valid_seen", valid, 1);
    check("draw_latency", lat_o, exp_lat);
    check("draw_value", value, exp_val);
    if (r != 0) check("draw_in_range", value < r, 1);
    check("draw_busy_done", busy, 1);
    check("draw_data", data, exp_end);
    tick();
    check("draw_idle_valid", valid, 0);
    check("draw_idle_busy", busy, 0);
    check("draw_value_hold", value, exp_val);
    mdl = exp_end;
  endtask

  typedef struct {
    logic         seed_we;
    logic [W-1:0] seed_in;
    logic         en;
    logic [W-1:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  bit   seen[256];

  initial begin
    int v, l, ev, el;
    logic [63:0] m8, fseed, es;
    bit found, f, saw_valid;
    logic [OW-1:0] r;

    vecs[0] = '{1'b0, 30'h0,        1'b1, 30'h3};
    vecs[1] = '{1'b0, 30'h0,        1'b1, 30'h7};
    vecs[2] = '{1'b0, 30'h0,        1'b1, 30'hF};
    vecs[3] = '{1'b0, 30'h0,        1'b1, 30'h1E};
    vecs[4] = '{1'b1, 30'h0,        1'b1, 30'h1};
    vecs[5] = '{1'b1, 30'h2A5,      1'b1, 30'h2A5};
    vecs[6] = '{1'b0, 30'h0,        1'b0, 30'h2A5};
    vecs[7] = '{1'b0, 30'h0,        1'b1, 30'h54A};
    vecs[8] = '{1'b1, 30'h3FFFFFFF, 1'b0, 30'h3FFFFFFF};
    vecs[9] = '{1'b0, 30'h0,        1'b1, 30'h3FFFFFFE};

    rst = 1'b1; en = 1'b0; seed_we = 1'b0; seed_in = '0; req = 1'b0; range_v = '0;
    en8 = 1'b0; seed_we8 = 1'b0; seed_in8 = '0; req8 = 1'b0; range8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data, 1);
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_value", value, 0);
    check("reset_data8", data8, 1);
    check("reset_busy8", busy8 | valid8, 0);
    check("reset_value8", value8, 0);
    rst = 1'b0;
    mdl = 64'd1;

    // 8-bit period
    en8 = 1'b1;
    m8 = 64'd1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      m8 = step_model(m8, 8);
      check("p8_step", data8, m8);
      check("p8_nonzero", data8 != 8'h0, 1);
      if (k < 255) begin
        check("p8_no_early_repeat", seen[data8], 0);
        seen[data8] = 1'b1;
      end
    end
    check("p8_period_return", data8, 1);
    en8 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      seed_we = vecs[i].seed_we;
      seed_in = vecs[i].seed_in;
      en      = vecs[i].en;
      tick();
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end
    seed_we = 1'b0;
    en = 1'b0;
    mdl = 64'(vecs[9].exp_data);

    load_seed(30'h12345AB);
    draw(8'd1, v, l);
    check("range1_value", v, 0);
    check("range1_latency", l, 2);
    load_seed(30'h12345AB);
    draw(8'd0, v, l);
    check("range0_value", v, 8'hAB);
    check("range0_latency", l, 2);

    found = 1'b0;
    fseed = 64'd0;
    for (int k = 0; k < 200000 && !found; k++) begin
      fseed = {34'd0, 22'($urandom), 8'hFF};
      model_draw(fseed, 129, ev, el, es, f);
      if (f) found = 1'b1;
    end
    check("forced_seed_found", found, 1);
    load_seed(W'(fseed));
    draw(8'd129, v, l);
    check("forced_latency", l, 17);
    check("forced_value", v, ev);

    load_seed(W'(fseed));
    req = 1'b1;
    range_v = 8'd129;
    tick();
    req = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_data", data, 1);
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid === 1'b1 || busy === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_valid", saw_valid, 0);
    mdl = 64'd1;

    for (int i = 0; i < 6000; i++) begin
      int mode;
      mode = $urandom_range(0, 4);
      if (mode == 0) begin
        repeat ($urandom_range(1, 6)) begin
          en = 1'($urandom_range(0, 1));
          seed_we = ($urandom_range(0, 7) == 0);
          seed_in = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
          tick();
          if (seed_we) mdl = (seed_in == '0) ? 64'd1 : 64'(seed_in);
          else if (en) mdl = step_model(mdl, W);
          check("free_run_data", data, mdl);
        end
        en = 1'b0;
        seed_we = 1'b0;
      end else begin
        r = (mode <= 2) ? 8'd200 : OW'($urandom_range(0, 255));
        draw(r, v, l);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
